gaussian_filter_3x3: RTL and testbench
======================================

# gaussian_filter_3x3

Applies a fixed 3×3 Gaussian kernel (1 2 1 / 2 4 2 / 1 2 1, ÷16, rounded) to the 8-bit window from the 3×3 matrix generator. The block sits directly downstream of that generator and consumes its `matrix11..matrix33` and `matrix_de/vs/hs`. It produces a filtered grey pixel stream with re-aligned sync signals for the next stage, such as binarisation, edge detection or HDMI output. Frame-border pixels, where the window is incomplete, are handled explicitly.

## Interface
Parameters:
- `IMG_WIDTH`, 11'd1920, active pixels per line
- `IMG_HEIGHT`, 11'd1080, active lines per frame
- `BORDER_MODE`, 1'b0, border pixel output: 0 = pass `matrix22` raw, 1 = output 0

Ports:
- `video_clk`  in  1  pixel clock; single clock domain
- `rst_n`  in  1  asynchronous, active-low reset
- `matrix_de`  in  1  window valid
- `matrix_vs`  in  1  vertical sync (active-high)
- `matrix_hs`  in  1  horizontal sync
- `matrix11..matrix33`  in  8 each  window; row 1 oldest line, column 3 newest pixel
- `gauss_de`  out  1  output pixel valid
- `gauss_vs`  out  1  `matrix_vs` delayed to align with the data
- `gauss_hs`  out  1  `matrix_hs` delayed to align with the data
- `gauss_data`  out  8  filtered pixel

## Operation
- **Position tracking.** `x_cnt` (12b) and `y_cnt` (12b) count `matrix_de` pixels.
  - `x_cnt` increments on every `matrix_de`. At `IMG_WIDTH-1` it wraps to 0 and `y_cnt` increments.
  - At (`IMG_WIDTH-1`, `IMG_HEIGHT-1`) both counters wrap to 0.
- **Frame resync.** A rising edge of `matrix_vs` (1-cycle registered compare) forces both counters to 0.
  - If `matrix_de` is high in the same cycle, the pixel is tagged (0,0) and `x_cnt` becomes 1. The clear takes priority over normal counting.
- **Border flag.** A pixel is border if `x_cnt==0`, `x_cnt==IMG_WIDTH-1`, `y_cnt==0` or `y_cnt==IMG_HEIGHT-1`, evaluated at the cycle the pixel is accepted. The flag is pipelined alongside the data.
- **Stage 1.** Row sums, 10-bit unsigned:
  - r1 = m11 + 2·m12 + m13
  - r2 = m21 + 2·m22 + m23
  - r3 = m31 + 2·m32 + m33
  - Registers `matrix22` and the border flag.
- **Stage 2.** s = r1 + 2·r2 + r3, 12-bit unsigned (max 4080).
- **Stage 3.** `gauss_data` is selected as follows:
  - `gauss_de` low: 0.
  - Border and `BORDER_MODE`=0: the delayed `matrix22`.
  - Border and `BORDER_MODE`=1: 0.
  - Otherwise: (s + 8) >> 4, taking bits [11:4] of a 12-bit sum. No saturation is needed because the maximum result is 255.
- **Non-valid cycles.** The pipeline advances every cycle regardless of `matrix_de`; there is no backpressure. Data captured while `matrix_de` is low is don't-care internally, but the output is forced to 0.

## Timing
- Latency is 3 cycles: a window sampled at edge N appears on `gauss_data` after edge N+3.
- `gauss_de`, `gauss_vs` and `gauss_hs` equal `matrix_de/vs/hs` delayed exactly 3 cycles. Sync and data therefore stay cycle-aligned.
- Throughput is one pixel per clock with no bubbles, including back-to-back lines with zero blanking.
- Reset values are 0 for every output, the counters, all pipeline registers and the vs-edge register.
- **Reset mid-frame.** All outputs drop to 0 asynchronously. After release, the counters restart at (0,0), and resync happens at the next `matrix_vs` rising edge.
- **Short or long lines.** Counters are not corrected within a frame; the `matrix_vs` edge is the only resync point.

## Structure
- Package `gauss_pkg` holds:
  - kernel weights
  - `ROW_W`=10 and `SUM_W`=12
  - `ROUND_OFS`=8 and `SHIFT`=4
  - `BORDER_PASS`/`BORDER_ZERO` constants
- Sub-module `gauss_pos_cnt` holds the x/y counters, vs-edge resync and border flag. It is parameterised by `IMG_WIDTH`/`IMG_HEIGHT` and reused by later 3×3 operators.
- The top level holds the 3-stage arithmetic and the sync delay lines.

## Test plan
- **Uniform window:** all nine taps = 100, non-border pixel -> `gauss_data`=100 exactly 3 cycles later, `gauss_de`=1.
- **Rounding:** only `matrix22`=3, all others 0 -> s=12, output (12+8)>>4 = 1. With `matrix22`=1 -> output 0.
- **Maximum:** all taps 255 -> output 255. Center 255 with all others 0 -> (1020+8)>>4 = 64.
- **Border handling:** `IMG_WIDTH`=8, `IMG_HEIGHT`=4, full frame.
  - Pixels at x∈{0,7} or y∈{0,3} output `matrix22` (`BORDER_MODE`=0) or 0 (`BORDER_MODE`=1).
  - Interior pixels are filtered.
  - Check the counter wrap at (7,3).
- **Sync and reset:**
  - `matrix_vs` rising edge coincident with `matrix_de` -> that pixel is treated as (0,0) border.
  - `gauss_vs/hs/de` trail the inputs by exactly 3 cycles.
  - Asserting `rst_n`=0 mid-line forces all outputs to 0 immediately, and the next frame after reset filters correctly.

Source files
------------

// File: rtl/gauss_pkg.sv
// rtl/gauss_pkg.sv - shared constants and kernel helpers for the 3x3 Gaussian filter
// Ports: none (package)
package gauss_pkg;

    // Kernel 1 2 1 / 2 4 2 / 1 2 1 is separable: each row uses 1 2 1 and the
    // rows are combined with the same 1 2 1 weights.
    localparam int K_OUT = 1;
    localparam int K_MID = 2;

    localparam int ROW_W = 10;
    localparam int SUM_W = 12;

    localparam int ROUND_OFS = 8;
    localparam int SHIFT     = 4;

    localparam logic BORDER_PASS = 1'b0;
    localparam logic BORDER_ZERO = 1'b1;

    function automatic logic [ROW_W-1:0] row_sum(input logic [7:0] a,
                                                 input logic [7:0] b,
                                                 input logic [7:0] c);
        return ROW_W'(K_OUT) * ROW_W'(a) + ROW_W'(K_MID) * ROW_W'(b) + ROW_W'(K_OUT) * ROW_W'(c);
    endfunction

    function automatic logic [SUM_W-1:0] col_sum(input logic [ROW_W-1:0] a,
                                                 input logic [ROW_W-1:0] b,
                                                 input logic [ROW_W-1:0] c);
        return SUM_W'(K_OUT) * SUM_W'(a) + SUM_W'(K_MID) * SUM_W'(b) + SUM_W'(K_OUT) * SUM_W'(c);
    endfunction

endpackage

// File: rtl/gauss_pos_cnt.sv
// rtl/gauss_pos_cnt.sv - pixel position tracker with vs-edge resync and border flag
// Ports:
//   video_clk, rst_n : clock, asynchronous active-low reset
//   de               : pixel valid
//   vs               : vertical sync (active-high); rising edge restarts the frame
//   border           : current pixel lies on the first/last row or column
module gauss_pos_cnt #(
    parameter logic [10:0] IMG_WIDTH  = 11'd1920,
    parameter logic [10:0] IMG_HEIGHT = 11'd1080
) (
    input  logic video_clk,
    input  logic rst_n,
    input  logic de,
    input  logic vs,
    output logic border
);

    localparam logic [11:0] X_LAST = 12'(IMG_WIDTH) - 12'd1;
    localparam logic [11:0] Y_LAST = 12'(IMG_HEIGHT) - 12'd1;

    logic [11:0] x_cnt;
    logic [11:0] y_cnt;
    logic        vs_d;
    logic        vs_rise;
    logic [11:0] tag_x;
    logic [11:0] tag_y;

    // A vs rising edge tags the coincident pixel as (0,0), so the clear
    // overrides the stored position before it is used.
    always_comb begin
        vs_rise = vs & ~vs_d;
        tag_x   = vs_rise ? 12'd0 : x_cnt;
        tag_y   = vs_rise ? 12'd0 : y_cnt;
        border  = (tag_x == 12'd0) || (tag_x == X_LAST) ||
                  (tag_y == 12'd0) || (tag_y == Y_LAST);
    end

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d  <= 1'b0;
            x_cnt <= 12'd0;
            y_cnt <= 12'd0;
        end else begin
            vs_d <= vs;
            if (de) begin
                if (tag_x == X_LAST) begin
                    x_cnt <= 12'd0;
                    y_cnt <= (tag_y == Y_LAST) ? 12'd0 : tag_y + 12'd1;
                end else begin
                    x_cnt <= tag_x + 12'd1;
                    y_cnt <= tag_y;
                end
            end else if (vs_rise) begin
                x_cnt <= 12'd0;
                y_cnt <= 12'd0;
            end
        end
    end

endmodule

// File: rtl/gaussian_filter_3x3.sv
// rtl/gaussian_filter_3x3.sv - 3-stage 3x3 Gaussian filter with aligned sync outputs
// Ports:
//   video_clk, rst_n          : pixel clock, asynchronous active-low reset
//   matrix_de/vs/hs           : window valid and syncs from the 3x3 matrix generator
//   matrix11..matrix33        : 8-bit window, row 1 oldest line, column 3 newest pixel
//   gauss_de/vs/hs            : inputs delayed 3 cycles, aligned with gauss_data
//   gauss_data                : filtered pixel (border pixels per BORDER_MODE)
module gaussian_filter_3x3
    import gauss_pkg::*;
#(
    parameter logic [10:0] IMG_WIDTH   = 11'd1920,
    parameter logic [10:0] IMG_HEIGHT  = 11'd1080,
    parameter logic        BORDER_MODE = 1'b0
) (
    input  logic       video_clk,
    input  logic       rst_n,
    input  logic       matrix_de,
    input  logic       matrix_vs,
    input  logic       matrix_hs,
    input  logic [7:0] matrix11,
    input  logic [7:0] matrix12,
    input  logic [7:0] matrix13,
    input  logic [7:0] matrix21,
    input  logic [7:0] matrix22,
    input  logic [7:0] matrix23,
    input  logic [7:0] matrix31,
    input  logic [7:0] matrix32,
    input  logic [7:0] matrix33,
    output logic       gauss_de,
    output logic       gauss_vs,
    output logic       gauss_hs,
    output logic [7:0] gauss_data
);

    logic             border;
    logic [ROW_W-1:0] r1, r2, r3;
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] sum_rnd;
    logic [7:0]       center_d1, center_d2;
    logic             border_d1, border_d2;
    logic [2:0]       sync_d1, sync_d2;

    gauss_pos_cnt #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT)
    ) u_pos (
        .video_clk (video_clk),
        .rst_n     (rst_n),
        .de        (matrix_de),
        .vs        (matrix_vs),
        .border    (border)
    );

    // Max sum 4080 + 8 still fits 12 bits, so bits [11:4] never exceed 255.
    assign sum_rnd = sum + SUM_W'(ROUND_OFS);

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            r1         <= '0;
            r2         <= '0;
            r3         <= '0;
            center_d1  <= '0;
            border_d1  <= 1'b0;
            sync_d1    <= '0;
            sum        <= '0;
            center_d2  <= '0;
            border_d2  <= 1'b0;
            sync_d2    <= '0;
            gauss_de   <= 1'b0;
            gauss_vs   <= 1'b0;
            gauss_hs   <= 1'b0;
            gauss_data <= '0;
        end else begin
            r1        <= row_sum(matrix11, matrix12, matrix13);
            r2        <= row_sum(matrix21, matrix22, matrix23);
            r3        <= row_sum(matrix31, matrix32, matrix33);
            center_d1 <= matrix22;
            border_d1 <= border;
            sync_d1   <= {matrix_de, matrix_vs, matrix_hs};

            sum       <= col_sum(r1, r2, r3);
            center_d2 <= center_d1;
            border_d2 <= border_d1;
            sync_d2   <= sync_d1;

            {gauss_de, gauss_vs, gauss_hs} <= sync_d2;
            if (!sync_d2[2])
                gauss_data <= 8'd0;
            else if (border_d2)
                gauss_data <= (BORDER_MODE == BORDER_ZERO) ? 8'd0 : center_d2;
            else
                gauss_data <= sum_rnd[SHIFT +: 8];
        end
    end

endmodule

// File: tb/tb_gaussian_filter_3x3.sv
// tb/tb_gaussian_filter_3x3.sv - self-checking bench for gaussian_filter_3x3
module tb_gaussian_filter_3x3;

    localparam int W = 8;
    localparam int H = 4;

    typedef struct packed {
        logic       de;
        logic       vs;
        logic       hs;
        logic [7:0] d_pass;
        logic [7:0] d_zero;
    } exp_t;

    logic       video_clk = 1'b0;
    logic       rst_n;
    logic       matrix_de, matrix_vs, matrix_hs;
    logic [7:0] matrix11, matrix12, matrix13;
    logic [7:0] matrix21, matrix22, matrix23;
    logic [7:0] matrix31, matrix32, matrix33;
    logic       de_p, vs_p, hs_p, de_z, vs_z, hs_z;
    logic [7:0] data_p, data_z;

    int   total = 0;
    int   bad = 0;
    int   m_idx;
    logic m_prev_vs;
    exp_t q[$];

    always #5 video_clk = ~video_clk;

    gaussian_filter_3x3 #(.IMG_WIDTH(11'(W)), .IMG_HEIGHT(11'(H)), .BORDER_MODE(1'b0)) u_pass (
        .video_clk(video_clk), .rst_n(rst_n),
        .matrix_de(matrix_de), .matrix_vs(matrix_vs), .matrix_hs(matrix_hs),
        .matrix11(matrix11), .matrix12(matrix12), .matrix13(matrix13),
        .matrix21(matrix21), .matrix22(matrix22), .matrix23(matrix23),
        .matrix31(matrix31), .matrix32(matrix32), .matrix33(matrix33),
        .gauss_de(de_p), .gauss_vs(vs_p), .gauss_hs(hs_p), .gauss_data(data_p)
    );

    gaussian_filter_3x3 #(.IMG_WIDTH(11'(W)), .IMG_HEIGHT(11'(H)), .BORDER_MODE(1'b1)) u_zero (
        .video_clk(video_clk), .rst_n(rst_n),
        .matrix_de(matrix_de), .matrix_vs(matrix_vs), .matrix_hs(matrix_hs),
        .matrix11(matrix11), .matrix12(matrix12), .matrix13(matrix13),
        .matrix21(matrix21), .matrix22(matrix22), .matrix23(matrix23),
        .matrix31(matrix31), .matrix32(matrix32), .matrix33(matrix33),
        .gauss_de(de_z), .gauss_vs(vs_z), .gauss_hs(hs_z), .gauss_data(data_z)
    );

    // Reference: weighted sum of the nine taps, then round-half-up divide by 16.
    function automatic logic [7:0] filt(input logic [8:0][7:0] w);
        int s;
        s = 1 * w[0] + 2 * w[1] + 1 * w[2]
          + 2 * w[3] + 4 * w[4] + 2 * w[5]
          + 1 * w[6] + 2 * w[7] + 1 * w[8];
        return 8'((s + 8) / 16);
    endfunction

    function automatic logic [8:0][7:0] pick(input int pattern, input int k);
        logic [8:0][7:0] w;
        for (int i = 0; i < 9; i++) w[i] = 8'($urandom_range(255, 0));
        if (pattern != 0) begin
            case (k % 6)
                0: w = {9{8'd100}};
                1: begin w = '0; w[4] = 8'd3; end
                2: begin w = '0; w[4] = 8'd1; end
                3: w = {9{8'd255}};
                4: begin w = '0; w[4] = 8'd255; end
                default: ;
            endcase
        end
        return w;
    endfunction

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 3; i++) q.push_back('0);
        m_idx     = 0;
        m_prev_vs = 1'b0;
    endtask

    // One clock: compare outputs against the entry queued three cycles ago,
    // then drive the next window and queue its expected result.
    task automatic step(input logic de, input logic vs, input logic hs, input logic [8:0][7:0] w);
        exp_t e;
        int   x, y;
        logic bd;
        @(posedge video_clk);
        #1;
        e = q.pop_front();
        total += 6;
        if (data_p !== e.d_pass) begin bad++; $display("FAIL data_pass t=%0t got=%0d exp=%0d", $time, data_p, e.d_pass); end
        if (data_z !== e.d_zero) begin bad++; $display("FAIL data_zero t=%0t got=%0d exp=%0d", $time, data_z, e.d_zero); end
        if (de_p !== e.de) begin bad++; $display("FAIL de_pass t=%0t got=%0b exp=%0b", $time, de_p, e.de); end
        if (de_z !== e.de) begin bad++; $display("FAIL de_zero t=%0t got=%0b exp=%0b", $time, de_z, e.de); end
        if (vs_p !== e.vs || vs_z !== e.vs) begin bad++; $display("FAIL vs t=%0t got=%0b/%0b exp=%0b", $time, vs_p, vs_z, e.vs); end
        if (hs_p !== e.hs || hs_z !== e.hs) begin bad++; $display("FAIL hs t=%0t got=%0b/%0b exp=%0b", $time, hs_p, hs_z, e.hs); end

        matrix_de = de; matrix_vs = vs; matrix_hs = hs;
        matrix11 = w[0]; matrix12 = w[1]; matrix13 = w[2];
        matrix21 = w[3]; matrix22 = w[4]; matrix23 = w[5];
        matrix31 = w[6]; matrix32 = w[7]; matrix33 = w[8];

        if (vs && !m_prev_vs) m_idx = 0;
        m_prev_vs = vs;
        e = '0;
        e.de = de; e.vs = vs; e.hs = hs;
        if (de) begin
            x  = m_idx % W;
            y  = (m_idx / W) % H;
            bd = (x == 0) || (x == W - 1) || (y == 0) || (y == H - 1);
            m_idx++;
            e.d_pass = bd ? w[4] : filt(w);
            e.d_zero = bd ? 8'd0 : filt(w);
        end
        q.push_back(e);
    endtask

    task automatic send_frame(input bit with_vs, input int blank_max, input int pattern);
        int k = 0;
        if (with_vs) begin
            step(0, 1, 0, pick(0, 0));
            step(0, 1, 0, pick(0, 0));
            step(0, 0, 0, pick(0, 0));
        end
        for (int y = 0; y < H; y++) begin
            int nb = $urandom_range(blank_max, 0);
            for (int b = 0; b < nb; b++) step(0, 0, 1, pick(0, 0));
            for (int x = 0; x < W; x++) begin
                step(1, 0, 0, pick(pattern, k));
                k++;
            end
        end
    endtask

    task automatic flush();
        for (int i = 0; i < 4; i++) step(0, 0, 0, pick(0, 0));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        matrix_de = 0; matrix_vs = 0; matrix_hs = 0;
        {matrix11, matrix12, matrix13, matrix21, matrix22, matrix23, matrix31, matrix32, matrix33} = '0;
        repeat (3) @(posedge video_clk);
        #2 rst_n = 1'b1;
        #1;
        total += 4;
        if (data_p !== 8'd0 || data_z !== 8'd0) begin bad++; $display("FAIL reset_data got=%0d/%0d exp=0", data_p, data_z); end
        if (de_p !== 1'b0 || de_z !== 1'b0) begin bad++; $display("FAIL reset_de got=%0b/%0b exp=0", de_p, de_z); end
        if (vs_p !== 1'b0 || vs_z !== 1'b0) begin bad++; $display("FAIL reset_vs got=%0b/%0b exp=0", vs_p, vs_z); end
        if (hs_p !== 1'b0 || hs_z !== 1'b0) begin bad++; $display("FAIL reset_hs got=%0b/%0b exp=0", hs_p, hs_z); end
        model_reset();
    endtask

    task automatic test_kernel_values();
        send_frame(1, 2, 1);
        flush();
    endtask

    task automatic test_border_random();
        send_frame(1, 2, 0);
        send_frame(1, 1, 0);
        flush();
    endtask

    task automatic test_back_to_back();
        // Second and third frames run without vs, so positions rely on the (7,3) wrap.
        send_frame(1, 0, 0);
        send_frame(0, 0, 0);
        send_frame(0, 0, 1);
        flush();
    endtask

    task automatic test_vs_with_de();
        send_frame(1, 0, 0);
        for (int i = 0; i < 11; i++) step(1, 0, 0, pick(0, 0));
        step(1, 1, 0, {9{8'd77}});
        for (int i = 0; i < 5; i++) step(1, 1, 0, pick(0, 0));
        step(0, 0, 0, pick(0, 0));
        for (int i = 0; i < 20; i++) step(1, 0, 0, pick(0, 0));
        flush();
    endtask

    task automatic test_reset_mid_line();
        send_frame(1, 0, 0);
        step(0, 1, 0, pick(0, 0));
        step(0, 0, 0, pick(0, 0));
        for (int i = 0; i < 12; i++) step(1, 0, 0, {9{8'd200}});
        #2 rst_n = 1'b0;
        #1;
        total += 4;
        if (data_p !== 8'd0 || data_z !== 8'd0) begin bad++; $display("FAIL async_rst_data got=%0d/%0d exp=0", data_p, data_z); end
        if (de_p !== 1'b0 || de_z !== 1'b0) begin bad++; $display("FAIL async_rst_de got=%0b/%0b exp=0", de_p, de_z); end
        if (vs_p !== 1'b0 || vs_z !== 1'b0) begin bad++; $display("FAIL async_rst_vs got=%0b/%0b exp=0", vs_p, vs_z); end
        if (hs_p !== 1'b0 || hs_z !== 1'b0) begin bad++; $display("FAIL async_rst_hs got=%0b/%0b exp=0", hs_p, hs_z); end
        matrix_de = 0; matrix_vs = 0; matrix_hs = 0;
        repeat (2) @(posedge video_clk);
        #2 rst_n = 1'b1;
        model_reset();
        send_frame(1, 1, 0);
        flush();
    endtask

    initial begin
        test_reset();
        test_kernel_values();
        test_border_random();
        test_back_to_back();
        test_vs_with_de();
        test_reset_mid_line();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
